// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit add/sub slice, one nibble per cycle.
// Optional build macro ADDSUB_ARB_SAT_EN clamps overflowing results to the signed limit.
module addsub_arbiter #(
  parameter int NIB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4*NIB-1:0] req0_a,
  input  logic [4*NIB-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4*NIB-1:0] req1_a,
  input  logic [4*NIB-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4*NIB-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_id
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            prio;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            sub_r;
  logic            id_r;
  logic [W-1:0]    y_r;

  logic            any_valid;
  logic            grant;
  logic            accept;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      nib_sum;
  logic [W-1:0]    y_next;
  logic            ovf_next;
  logic [W-1:0]    y_final;

  // A lone valid requester always wins; a tie goes to whoever is owed a turn.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant = prio;
    end
  end

  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // One ripple slice: the current nibble plus the carry held over from the previous one.
  always_comb begin
    a_nib   = a_r[{idx, 2'b00} +: 4];
    b_nib   = b_r[{idx, 2'b00} +: 4] ^ {4{sub_r}};
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    y_next  = y_r;
    y_next[{idx, 2'b00} +: 4] = nib_sum[3:0];
    ovf_next = (a_r[W-1] == (b_r[W-1] ^ sub_r)) && (y_next[W-1] != a_r[W-1]);
`ifdef ADDSUB_ARB_SAT_EN
    if (ovf_next) begin
      y_final = a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y_final = y_next;
    end
`else
    y_final = y_next;
`endif
  end

  // Response fields are loaded on the final nibble so they sit still for the whole of DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      id_r      <= 1'b0;
      y_r       <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= grant ? req1_a : req0_a;
            b_r   <= grant ? req1_b : req0_b;
            sub_r <= grant ? req1_sub : req0_sub;
            carry <= grant ? req1_sub : req0_sub;
            id_r  <= grant;
            idx   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          y_r   <= y_next;
          carry <= nib_sum[4];
          if (idx == IW'(NIB - 1)) begin
            idx       <= '0;
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_y     <= y_final;
            rsp_cout  <= nib_sum[4];
            rsp_ovf   <= ovf_next;
            rsp_id    <= id_r;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
